sd_stream_reader: RTL and testbench

Upstream request engine for the sdcard block. It takes a start byte address and a byte count, then issues one sd_read per byte on the sdcard byte interface. It collects each returned byte into a small FIFO and presents the bytes as a valid/ready stream, so the bootloader/DMA side can read sequentially without driving the sdcard handshake itself.

---
 rtl/sd_pkg.sv | 15 +
 rtl/sd_byte_fifo.sv | 59 +++++
 rtl/sd_stream_reader.sv | 135 +++++++++++++
 tb/tb_sd_stream_reader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the sdcard streaming blocks: FSM state encoding and
// the fixed sdcard interface widths.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GUARD,
      WAIT
   } state_t;

   localparam int SD_ADDR_W = 32;
   localparam int SD_BYTE_W = 8;

endpackage

// File: rtl/sd_byte_fifo.sv
// Byte FIFO with first-word-fall-through output. Pointers wrap naturally at
// DEPTH (power of two, minimum 2). Pushes when full and pops when empty are
// ignored. Shared by the read and write streamers.
module sd_byte_fifo
   import sd_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [SD_BYTE_W-1:0]         din,
   input  logic                         pop,
   output logic [SD_BYTE_W-1:0]         dout,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [SD_BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write port.
   // NOTE: the array has no reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sd_stream_reader.sv
// Sequential byte reader on top of the sdcard byte interface. Issues one
// sd_read per byte from start_addr for length bytes, buffers the results in
// sd_byte_fifo and presents them as a valid/ready stream.
// Optional feature macro: SD_STREAM_CHECKSUM_EN adds a 16-bit running sum of
// the captured bytes on output checksum.
module sd_stream_reader
   import sd_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16,
   parameter int ADDR_W     = SD_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [LEN_W-1:0]      length,
   output logic                  busy,
   output logic                  done,
   output logic [SD_BYTE_W-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_W-1:0]     sd_addr,
   output logic                  sd_read,
   output logic                  sd_write,
   input  logic [SD_BYTE_W-1:0]  sd_read_data,
   input  logic                  sd_ready
`ifdef SD_STREAM_CHECKSUM_EN
   ,
   output logic [15:0]           checksum
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t          state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;

   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            capture;
   logic            fifo_push;
   logic            slot_free;

   // The free-slot check in ISSUE reserves room for the byte that WAIT will
   // capture, so the capture can never be dropped even if the consumer stalls.
   assign slot_free = (fifo_count < CW'(FIFO_DEPTH));
   assign capture   = (state == WAIT) && sd_ready;
   assign fifo_push = capture && !fifo_full;

   assign sd_addr   = addr;
   assign sd_write  = 1'b0;
   assign out_valid = !fifo_empty;

   sd_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (sd_read_data),
      .pop   (out_ready),
      .dout  (out_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Request FSM: one sdcard read per byte, with a guard cycle so the stale
   // sd_ready from the previous access is not mistaken for a result.
   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values of state, addr and remaining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sd_read   <= 1'b0;
`ifdef SD_STREAM_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         done    <= 1'b0;
         sd_read <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
`ifdef SD_STREAM_CHECKSUM_EN
                  checksum <= '0;
`endif
                  if (length != '0) begin
                     addr      <= start_addr;
                     remaining <= length;
                     busy      <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (sd_ready && slot_free) begin
                  sd_read <= 1'b1;
                  state   <= GUARD;
               end
            end
            GUARD: begin
               state <= WAIT;
            end
            WAIT: begin
               if (sd_ready) begin
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
`ifdef SD_STREAM_CHECKSUM_EN
                  checksum  <= checksum + {8'h00, sd_read_data};
`endif
                  if (remaining == LEN_W'(1)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_stream_reader.sv
// Directed bench for sd_stream_reader with a behavioural sdcard model that
// drops sd_ready the cycle after sd_read and returns addr[7:0] after a
// programmable latency. Build with SD_STREAM_CHECKSUM_EN to also check checksum.
module tb_sd_stream_reader;

   localparam int FIFO_DEPTH = 16;
   localparam int LEN_W      = 16;
   localparam int ADDR_W     = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] sd_addr;
   logic              sd_read;
   logic              sd_write;
   logic [7:0]        sd_read_data;
   logic              sd_ready;
`ifdef SD_STREAM_CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   int compared   = 0;
   int mismatched = 0;

   sd_stream_reader #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .start_addr   (start_addr),
      .length       (length),
      .busy         (busy),
      .done         (done),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sd_addr      (sd_addr),
      .sd_read      (sd_read),
      .sd_write     (sd_write),
      .sd_read_data (sd_read_data),
      .sd_ready     (sd_ready)
`ifdef SD_STREAM_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   always #5 clk = ~clk;

   // sdcard model
   int          sd_lat = 5;
   int          sd_cnt;
   logic [31:0] sd_req_addr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sd_ready     <= 1'b1;
         sd_cnt       <= 0;
         sd_read_data <= 8'h00;
         sd_req_addr  <= '0;
      end else if (sd_read) begin
         sd_ready    <= 1'b0;
         sd_cnt      <= sd_lat;
         sd_req_addr <= sd_addr;
      end else if (sd_cnt != 0) begin
         sd_cnt <= sd_cnt - 1;
         if (sd_cnt == 1) begin
            sd_ready     <= 1'b1;
            sd_read_data <= sd_req_addr[7:0];
         end
      end
   end

   // Observation log, sampled mid-cycle
   logic [31:0] reads[$];
   logic [7:0]  rx[$];
   int          done_cnt;
   bit          busy_seen;

   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (busy) busy_seen = 1'b1;
         if (sd_read) reads.push_back(sd_addr);
         if (out_valid && out_ready) rx.push_back(out_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, want finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      reads.delete();
      rx.delete();
      done_cnt  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] a, input logic [15:0] n);
      start      = 1'b1;
      start_addr = a;
      length     = n;
      cyc();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < budget) begin
         cyc();
         n++;
      end
      compared++;
      if (done_cnt == base) begin
         mismatched++;
         $display("FAIL %s_done_timeout: got no done in %0d cycles, want done", name, budget);
      end
   endtask

   task automatic check_reads(input string name, input int n, input logic [31:0] base);
      compared++;
      if (reads.size() != n) begin
         mismatched++;
         $display("FAIL %s_read_count: got %0d want %0d", name, reads.size(), n);
      end
      for (int i = 0; i < n; i++) begin
         logic [31:0] got;
         logic [31:0] want;
         got  = (i < reads.size()) ? reads[i] : 32'hxxxxxxxx;
         want = base + 32'(i);
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("FAIL %s_read_addr[%0d]: got %h want %h", name, i, got, want);
         end
      end
   endtask

   task automatic check_rx(input string name, input int n, input logic [7:0] base);
      compared++;
      if (rx.size() != n) begin
         mismatched++;
         $display("FAIL %s_rx_count: got %0d want %0d", name, rx.size(), n);
      end
      for (int i = 0; i < n; i++) begin
         logic [7:0] got;
         logic [7:0] want;
         got  = (i < rx.size()) ? rx[i] : 8'hxx;
         want = base + 8'(i);
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("FAIL %s_rx_data[%0d]: got %h want %h", name, i, got, want);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      compared++;
      if ({busy, done, out_valid, sd_read, sd_write} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got busy,done,valid,rd,wr=%b want 00000",
                  {busy, done, out_valid, sd_read, sd_write});
      end
      compared++;
      if (sd_addr !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_sd_addr: got %h want 00000000", sd_addr);
      end
`ifdef SD_STREAM_CHECKSUM_EN
      compared++;
      if (checksum !== 16'h0) begin
         mismatched++;
         $display("FAIL reset_checksum: got %h want 0000", checksum);
      end
`endif
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      clear_log();
      sd_lat    = 5;
      out_ready = 1'b1;
      do_start(32'h0000_0200, 16'd4);
      wait_done(200, "basic");
      repeat (4) cyc();
      check_reads("basic", 4, 32'h0000_0200);
      check_rx("basic", 4, 8'h00);
      compared++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_done_busy: got done_cnt=%0d busy=%b want 1,0", done_cnt, busy);
      end
`ifdef SD_STREAM_CHECKSUM_EN
      compared++;
      if (checksum !== 16'h0006) begin
         mismatched++;
         $display("FAIL basic_checksum: got %h want 0006", checksum);
      end
`endif
   endtask

   task automatic test_backpressure();
      clear_log();
      sd_lat    = 2;
      out_ready = 1'b0;
      do_start(32'h0000_1000, 16'd40);
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("FAIL bp_busy_rise: got %b want 1", busy);
      end
      repeat (100) cyc();
      compared++;
      if (reads.size() != FIFO_DEPTH || rx.size() != 0) begin
         mismatched++;
         $display("FAIL bp_stall: got reads=%0d rx=%0d want 16,0", reads.size(), rx.size());
      end
      compared++;
      if ({out_valid, busy, sd_read} !== 3'b110 || done_cnt != 0) begin
         mismatched++;
         $display("FAIL bp_stall_flags: got valid,busy,rd=%b done_cnt=%0d want 110,0",
                  {out_valid, busy, sd_read}, done_cnt);
      end
      out_ready = 1'b1;
      wait_done(2000, "bp");
      repeat (20) cyc();
      check_reads("bp", 40, 32'h0000_1000);
      check_rx("bp", 40, 8'h00);
      compared++;
      if (done_cnt != 1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_done_drain: got done_cnt=%0d valid=%b want 1,0", done_cnt, out_valid);
      end
`ifdef SD_STREAM_CHECKSUM_EN
      compared++;
      if (checksum !== 16'h030C) begin
         mismatched++;
         $display("FAIL bp_checksum: got %h want 030c", checksum);
      end
`endif
   endtask

   task automatic test_zero_length();
      clear_log();
      out_ready = 1'b1;
      do_start(32'h0000_0ABC, 16'd0);
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL zero_done_pulse: got %b want 1", done);
      end
      cyc();
      compared++;
      if (done !== 1'b0) begin
         mismatched++;
         $display("FAIL zero_done_width: got %b want 0", done);
      end
      repeat (3) cyc();
      compared++;
      if (busy_seen || reads.size() != 0 || done_cnt != 1) begin
         mismatched++;
         $display("FAIL zero_quiet: got busy_seen=%b reads=%0d done_cnt=%0d want 0,0,1",
                  busy_seen, reads.size(), done_cnt);
      end
`ifdef SD_STREAM_CHECKSUM_EN
      compared++;
      if (checksum !== 16'h0000) begin
         mismatched++;
         $display("FAIL zero_checksum: got %h want 0000", checksum);
      end
`endif
   endtask

   task automatic test_addr_wrap();
      clear_log();
      sd_lat    = 3;
      out_ready = 1'b1;
      do_start(32'hFFFF_FFFE, 16'd3);
      wait_done(200, "wrap");
      repeat (4) cyc();
      check_reads("wrap", 3, 32'hFFFF_FFFE);
      check_rx("wrap", 3, 8'hFE);
      compared++;
      if (sd_addr !== 32'h0000_0001) begin
         mismatched++;
         $display("FAIL wrap_final_addr: got %h want 00000001", sd_addr);
      end
`ifdef SD_STREAM_CHECKSUM_EN
      compared++;
      if (checksum !== 16'h01FD) begin
         mismatched++;
         $display("FAIL wrap_checksum: got %h want 01fd", checksum);
      end
`endif
   endtask

   task automatic test_ignored_start_and_reset();
      int n;
      clear_log();
      sd_lat    = 5;
      out_ready = 1'b0;
      do_start(32'h0000_0300, 16'd4);
      repeat (2) cyc();
      do_start(32'h0000_0900, 16'd2);
      n = 0;
      while (reads.size() < 2 && n < 200) begin
         cyc();
         n++;
      end
      cyc();
      check_reads("ignored", 2, 32'h0000_0300);
      compared++;
      if ({out_valid, busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL ignored_midflight: got valid,busy=%b want 11", {out_valid, busy});
      end
      #2 rst = 1'b1;
      #1;
      compared++;
      if ({out_valid, busy, sd_read, done} !== 4'b0000) begin
         mismatched++;
         $display("FAIL async_reset: got valid,busy,rd,done=%b want 0000",
                  {out_valid, busy, sd_read, done});
      end
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      clear_log();
      out_ready = 1'b1;
      do_start(32'h0000_0040, 16'd2);
      wait_done(200, "post_reset");
      repeat (4) cyc();
      check_reads("post_reset", 2, 32'h0000_0040);
      check_rx("post_reset", 2, 8'h40);
      compared++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_done: got done_cnt=%0d busy=%b want 1,0", done_cnt, busy);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      out_ready  = 1'b0;
      done_cnt   = 0;
      busy_seen  = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_length();
      test_addr_wrap();
      test_ignored_start_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
